pwm_generator: RTL and testbench

PWM_GENERATOR -- requirements
Module: pwm_generator

---
 rtl/pwm_pkg.sv | 12 +
 rtl/edge_sync.sv | 30 +++
 rtl/pwm_generator.sv | 122 ++++++++++++
 tb/tb_pwm_generator.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared state encoding and default sizing for the PWM generator.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH       = 8;
  localparam int unsigned PWM_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

endpackage

// File: rtl/edge_sync.sv
// Brings an asynchronous level into the clk_in domain and emits a registered
// one-cycle pulse on each rising edge; falling edges produce nothing.
module edge_sync
  import pwm_pkg::*;
#(
  parameter int unsigned STAGES = PWM_SYNC_STAGES
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Pulse appears STAGES+1 cycles after d rises.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      rise   <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_prev <= r_sync[STAGES-1];
      rise   <= r_sync[STAGES-1] & ~r_prev;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// Tick-driven PWM with double-buffered period/duty config and valid/ready load.
// Define PWM_GENERATOR_COMPLEMENT_EN to add the registered complement output pwm_out_n.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = PWM_WIDTH,
  parameter int unsigned SYNC_STAGES = PWM_SYNC_STAGES
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_div,
  input  logic             enable,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             pwm_out,
  output logic             period_done
`ifdef PWM_GENERATOR_COMPLEMENT_EN
  ,
  output logic             pwm_out_n
`endif
);

  pwm_state_t       r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period_sh;
  logic [WIDTH-1:0] r_duty_sh;
  logic [WIDTH-1:0] r_pend_period;
  logic [WIDTH-1:0] r_pend_duty;
  logic             r_pending;

  logic             w_tick;
  logic             w_xfer;
  logic             w_boundary;
  logic             w_load;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_duty_nxt;
  logic             w_pwm_nxt;

  edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (clk_div),
    .rise   (w_tick)
  );

  // A boundary needs the run to continue this cycle; a tick coinciding with disable is dropped.
  assign w_xfer     = cfg_valid & cfg_ready;
  assign w_boundary = (r_state == RUN) & enable & w_tick & (r_cnt == r_period_sh);
  assign w_load     = r_pending & ((r_state == IDLE) | w_boundary);
  assign w_duty_nxt = w_load ? r_pend_duty : r_duty_sh;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!enable || r_state == IDLE) begin
      w_cnt_nxt = '0;
    end else if (w_tick) begin
      w_cnt_nxt = w_boundary ? '0 : r_cnt + WIDTH'(1);
    end
  end

  // Next state is RUN exactly when enable is high, so the output uses enable directly.
  assign w_pwm_nxt = enable & (w_cnt_nxt < w_duty_nxt);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_period_sh   <= '0;
      r_duty_sh     <= '0;
      r_pend_period <= '0;
      r_pend_duty   <= '0;
      r_pending     <= 1'b0;
      cfg_ready     <= 1'b1;
      pwm_out       <= 1'b0;
      period_done   <= 1'b0;
`ifdef PWM_GENERATOR_COMPLEMENT_EN
      pwm_out_n     <= 1'b0;
`endif
    end else begin
      period_done <= 1'b0;
      case (r_state)
        IDLE: if (enable) r_state <= RUN;
        RUN: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (w_boundary) begin
            period_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      r_cnt <= w_cnt_nxt;

      if (w_load) begin
        r_period_sh <= r_pend_period;
        r_duty_sh   <= r_pend_duty;
      end

      // Transfer needs an empty pending slot, so it never collides with a load.
      if (w_xfer) begin
        r_pend_period <= cfg_period;
        r_pend_duty   <= cfg_duty;
        r_pending     <= 1'b1;
        cfg_ready     <= 1'b0;
      end else if (w_load) begin
        r_pending     <= 1'b0;
        cfg_ready     <= 1'b1;
      end

      pwm_out <= w_pwm_nxt;
`ifdef PWM_GENERATOR_COMPLEMENT_EN
      pwm_out_n <= enable & ~w_pwm_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Randomized self-checking bench for pwm_generator against a behavioural model.
// Honours PWM_GENERATOR_COMPLEMENT_EN to also check pwm_out_n.
module tb_pwm_generator;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SYNC  = 2;
  localparam int          LIM   = 3000;

  logic             clk_in     = 1'b0;
  logic             rst        = 1'b1;
  logic             clk_div    = 1'b0;
  logic             enable     = 1'b0;
  logic             cfg_valid  = 1'b0;
  logic [WIDTH-1:0] cfg_period = '0;
  logic [WIDTH-1:0] cfg_duty   = '0;
  logic             cfg_ready;
  logic             pwm_out;
  logic             period_done;
`ifdef PWM_GENERATOR_COMPLEMENT_EN
  logic             pwm_out_n;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit m_run, m_pend, m_ready, m_pwm, m_done, m_tick, m_xfer;
  int m_cnt, m_per, m_duty, m_pper, m_pduty;
  bit hist [SYNC+2];

  // clk_div generator
  bit div_en, div_rand;
  int div_half, div_cnt;

  pwm_generator #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .clk_div     (clk_div),
    .enable      (enable),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .pwm_out     (pwm_out),
    .period_done (period_done)
`ifdef PWM_GENERATOR_COMPLEMENT_EN
    ,
    .pwm_out_n   (pwm_out_n)
`endif
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_ready = 1; m_pwm = 0; m_done = 0; m_tick = 0; m_xfer = 0;
    m_cnt = 0; m_per = 0; m_duty = 0; m_pper = 0; m_pduty = 0;
    foreach (hist[i]) hist[i] = 0;
  endtask

  // One rising clk_in edge worth of the specified behaviour, applied in spec order.
  task automatic model_step();
    bit tick;
    tick   = hist[SYNC] && !hist[SYNC+1];
    for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = clk_div;
    m_xfer = cfg_valid && m_ready;
    m_done = 0;
    if (!m_run) begin
      if (m_pend) begin m_per = m_pper; m_duty = m_pduty; m_pend = 0; end
      if (enable) begin m_run = 1; m_cnt = 0; end
    end else if (!enable) begin
      m_run = 0; m_cnt = 0;
    end else if (tick) begin
      if (m_cnt == m_per) begin
        m_cnt = 0; m_done = 1;
        if (m_pend) begin m_per = m_pper; m_duty = m_pduty; m_pend = 0; end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (m_xfer) begin m_pper = int'(cfg_period); m_pduty = int'(cfg_duty); m_pend = 1; end
    m_ready = !m_pend;
    m_pwm   = m_run && (m_cnt < m_duty);
    m_tick  = hist[SYNC] && !hist[SYNC+1];
  endtask

  task automatic check_outputs();
    check_eq("pwm_out", 32'(pwm_out), 32'(m_pwm));
    check_eq("period_done", 32'(period_done), 32'(m_done));
    check_eq("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    check_eq("tick", 32'(dut.w_tick), 32'(m_tick));
`ifdef PWM_GENERATOR_COMPLEMENT_EN
    check_eq("pwm_out_n", 32'(pwm_out_n), 32'(m_run && !m_pwm));
`endif
  endtask

  // Inputs are set just after a falling edge; the model steps for the coming rising edge.
  task automatic cycle();
    if (div_en) begin
      div_cnt++;
      if (div_cnt >= div_half) begin
        clk_div = ~clk_div;
        div_cnt = 0;
        if (div_rand) div_half = int'($urandom_range(1, 5));
      end
    end
    if (rst) model_reset();
    else     model_step();
    @(negedge clk_in);
    check_outputs();
  endtask

  task automatic offer_cfg(input int p, input int d);
    int waited;
    waited     = 0;
    cfg_period = WIDTH'(p);
    cfg_duty   = WIDTH'(d);
    cfg_valid  = 1'b1;
    do begin
      cycle();
      waited++;
    end while (!m_xfer && waited < LIM);
    cfg_valid = 1'b0;
    check_eq("cfg_taken", 32'(cfg_ready), 32'(0));
  endtask

  initial begin
    int lat, ticks, w, p;
    model_reset();
    div_en = 0; div_rand = 0; div_half = 4; div_cnt = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) cycle();
    check_eq("reset_ready", 32'(cfg_ready), 32'(1));
    check_eq("reset_pwm", 32'(pwm_out), 32'(0));
    rst = 1'b0;
    repeat (2) cycle();

    // Basic waveform, then a mid-period config change
    offer_cfg(3, 2);
    div_en = 1; enable = 1'b1;
    repeat (80) cycle();
    repeat (5) cycle();
    offer_cfg(7, 4);
    repeat (150) cycle();

    // Extremes
    offer_cfg(5, 0);  repeat (120) cycle();
    offer_cfg(7, 9);  repeat (150) cycle();
    offer_cfg(0, 1);  repeat (60)  cycle();

    // Disable at cnt==2
    offer_cfg(7, 4);
    w = 0;
    while ((m_cnt != 2 || !m_run) && w < LIM) begin cycle(); w++; end
    enable = 1'b0;
    cycle();
    check_eq("cnt_cleared", 32'(dut.r_cnt), 32'(0));
    check_eq("pwm_disabled", 32'(pwm_out), 32'(0));
    repeat (5) cycle();
    enable = 1'b1;
    repeat (20) cycle();

    // Single clk_div edge timing, then held high
    enable = 1'b0; div_en = 0; clk_div = 1'b0;
    repeat (8) cycle();
    clk_div = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (lat == 0 && dut.w_tick) lat = i;
    end
    check_eq("tick_latency", 32'(lat), 32'(SYNC + 1));
    ticks = 0;
    repeat (20) begin cycle(); ticks += int'(dut.w_tick); end
    check_eq("no_tick_while_high", 32'(ticks), 32'(0));

    // Asynchronous reset mid-run with a config pending
    clk_div = 1'b0; div_cnt = 0; div_half = 4; div_en = 1; enable = 1'b1;
    offer_cfg(40, 20);
    repeat (100) cycle();
    offer_cfg(9, 3);
    repeat (10) cycle();
    check_eq("pending_before_reset", 32'(cfg_ready), 32'(0));
    @(posedge clk_in);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_pwm", 32'(pwm_out), 32'(0));
    check_eq("rst_done", 32'(period_done), 32'(0));
    check_eq("rst_ready", 32'(cfg_ready), 32'(1));
    check_eq("rst_cnt", 32'(dut.r_cnt), 32'(0));
    model_reset();
    @(negedge clk_in);
    check_outputs();
    repeat (2) cycle();
    rst = 1'b0;
    repeat (200) cycle();

    // Randomized traffic
    div_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 99) < 97);
      cfg_valid = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 6));
      cfg_period = WIDTH'(p);
      cfg_duty   = WIDTH'($urandom_range(0, p + 2));
      cycle();
    end
    cfg_valid = 1'b0;
    repeat (10) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
